// File: rtl/n_bit_therm_min_max.sv
// Registered compare/exchange cell for thermometer-coded operands.
// Inputs are popcount-normalised so bubbled codes still yield canonical min/max.
module n_bit_therm_min_max #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] max
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    w_cnt_a;
  logic [CW-1:0]    w_cnt_b;
  logic [WIDTH-1:0] w_na;
  logic [WIDTH-1:0] w_nb;
  logic [WIDTH-1:0] r_min;
  logic [WIDTH-1:0] r_max;

  // Ones-count of each operand; this is the value a bubbled code stands for.
  always_comb begin
    w_cnt_a = '0;
    w_cnt_b = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_a = w_cnt_a + CW'(a[i]);
      w_cnt_b = w_cnt_b + CW'(b[i]);
    end
  end

  // Rebuild canonical codes: bit i set iff i is below the count.
  always_comb begin
    w_na = '0;
    w_nb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_na[i] = (CW'(i) < w_cnt_a);
      w_nb[i] = (CW'(i) < w_cnt_b);
    end
  end

  // On canonical codes AND selects the smaller count and OR the larger.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_min <= '0;
      r_max <= '0;
    end else begin
      r_min <= w_na & w_nb;
      r_max <= w_na | w_nb;
    end
  end

  assign min = r_min;
  assign max = r_max;

endmodule

// File: tb/tb_n_bit_therm_min_max.sv
// Self-checking bench for n_bit_therm_min_max against a popcount-based model.
module tb_n_bit_therm_min_max;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] min;
  logic [W-1:0] max;

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0] exp_q[$];

  n_bit_therm_min_max #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .min (min),
    .max (max)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  function automatic int pc(input logic [W-1:0] x);
    int c;
    c = 0;
    for (int i = 0; i < W; i++) c += int'(x[i]);
    return c;
  endfunction

  function automatic logic [W-1:0] canon(input int k);
    logic [31:0] t;
    t = (32'd1 << k) - 32'd1;
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] model_min(input logic [W-1:0] x, input logic [W-1:0] y);
    return canon((pc(x) < pc(y)) ? pc(x) : pc(y));
  endfunction

  function automatic logic [W-1:0] model_max(input logic [W-1:0] x, input logic [W-1:0] y);
    return canon((pc(x) > pc(y)) ? pc(x) : pc(y));
  endfunction

  // driver: present a pair before the edge, then sample just after it
  task automatic drive_pair(input logic [W-1:0] ta, input logic [W-1:0] tb);
    @(negedge clk);
    a = ta;
    b = tb;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a   = 4'b1111;
    b   = 4'b0111;
    #2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (min !== 4'b0000 || max !== 4'b0000)
        $display("FAIL reset_hold cyc=%0d min=%b max=%b expected 0000/0000", i, min, max);
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (min !== 4'b0111 || max !== 4'b1111)
      $display("FAIL reset_release min=%b max=%b expected 0111/1111", min, max);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [W-1:0] pa[4];
    logic [W-1:0] pb[4];
    logic [W-1:0] em[4];
    logic [W-1:0] ex[4];
    pa = '{4'b0001, 4'b0000, 4'b0011, 4'b0111};
    pb = '{4'b0000, 4'b0011, 4'b1111, 4'b0011};
    em = '{4'b0000, 4'b0000, 4'b0011, 4'b0011};
    ex = '{4'b0001, 4'b0011, 4'b1111, 4'b0111};
    for (int i = 0; i < 4; i++) begin
      drive_pair(pa[i], pb[i]);
      repeat (4) @(posedge clk);
      #1;
      n_total++;
      if (min !== em[i] || max !== ex[i])
        $display("FAIL basic_%0d a=%b b=%b min=%b max=%b expected %b/%b",
                 i, pa[i], pb[i], min, max, em[i], ex[i]);
      else n_pass++;
    end
  endtask

  task automatic test_bubble();
    drive_pair(4'b1000, 4'b0001);
    n_total++;
    if (min !== 4'b0001 || max !== 4'b0001)
      $display("FAIL bubble_1000 min=%b max=%b expected 0001/0001", min, max);
    else n_pass++;
    drive_pair(4'b0101, 4'b0111);
    n_total++;
    if (min !== 4'b0011 || max !== 4'b0111)
      $display("FAIL bubble_0101 min=%b max=%b expected 0011/0111", min, max);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] pa[3];
    logic [W-1:0] pb[3];
    logic [W-1:0] em;
    logic [W-1:0] ex;
    pa = '{4'b0000, 4'b1111, 4'b0011};
    pb = '{4'b1111, 4'b0000, 4'b0011};
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model_min(pa[i], pb[i]));
      exp_q.push_back(model_max(pa[i], pb[i]));
      drive_pair(pa[i], pb[i]);
      em = exp_q.pop_front();
      ex = exp_q.pop_front();
      n_total++;
      if (min !== em || max !== ex)
        $display("FAIL latency_%0d min=%b max=%b expected %b/%b", i, min, max, em, ex);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    drive_pair(4'b1111, 4'b0001);
    n_total++;
    if (max !== 4'b1111)
      $display("FAIL async_pre max=%b expected 1111", max);
    else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_total++;
    if (min !== 4'b0000 || max !== 4'b0000)
      $display("FAIL async_assert min=%b max=%b expected 0000/0000", min, max);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (min !== 4'b0000 || max !== 4'b0000)
      $display("FAIL async_hold min=%b max=%b expected 0000/0000", min, max);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (min !== 4'b0001 || max !== 4'b1111)
      $display("FAIL async_release min=%b max=%b expected 0001/1111", min, max);
    else n_pass++;
  endtask

  task automatic test_sweep();
    logic [W-1:0] ta;
    logic [W-1:0] tb;
    int errs;
    errs = 0;
    for (int i = 0; i < (1 << (2 * W)); i++) begin
      ta = W'(i);
      tb = W'(i >> W);
      drive_pair(ta, tb);
      n_total++;
      if (min !== model_min(ta, tb) || max !== model_max(ta, tb)) begin
        errs++;
        if (errs < 10)
          $display("FAIL sweep a=%b b=%b min=%b max=%b expected %b/%b",
                   ta, tb, min, max, model_min(ta, tb), model_max(ta, tb));
      end else n_pass++;
      n_total++;
      if (min !== canon(pc(min)) || max !== canon(pc(max)) ||
          (min & max) !== min || pc(min) > pc(max)) begin
        errs++;
        if (errs < 10)
          $display("FAIL invariant a=%b b=%b min=%b max=%b", ta, tb, min, max);
      end else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ta;
    logic [W-1:0] tb;
    logic [W-1:0] em;
    logic [W-1:0] ex;
    for (int i = 0; i < 200; i++) begin
      ta = W'($urandom_range(0, (1 << W) - 1));
      tb = W'($urandom_range(0, (1 << W) - 1));
      exp_q.push_back(model_min(ta, tb));
      exp_q.push_back(model_max(ta, tb));
      drive_pair(ta, tb);
      em = exp_q.pop_front();
      ex = exp_q.pop_front();
      n_total++;
      if (min !== em || max !== ex)
        $display("FAIL random_%0d a=%b b=%b min=%b max=%b expected %b/%b",
                 i, ta, tb, min, max, em, ex);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b0;
    a   = '0;
    b   = '0;
    test_reset();
    test_basic();
    test_bubble();
    test_back_to_back();
    test_async_reset();
    test_sweep();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
